min_search_ctrl: RTL and testbench
==================================

# min_search_ctrl

Sequencer for the distance-minimum datapath. On a start pulse it reads a programmable number of candidate distances from the candidate buffer, one per cycle, and folds them through a pairwise minimum. It then reports the smallest distance and its candidate index with a one-cycle done pulse. It sits between the disparity/distance generator, which fills the candidate buffer, and the downstream consumer of the best match.

## Interface
Parameters:
- DIST_W, 18, distance width.
- IDX_W, 8, candidate index width (max 2^IDX_W candidates).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  start pulse; sampled only in IDLE.
- cand_num  in  IDX_W+1  number of candidates N (0..2^IDX_W); sampled with start.
- rd_en  out  1  candidate buffer read strobe.
- rd_addr  out  IDX_W  candidate buffer read address.
- rd_data  in  DIST_W  distance returned exactly 1 cycle after rd_en.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; result outputs are valid from this cycle.
- found  out  1  1 if N>0 in the last search.
- best_dist  out  DIST_W  minimum distance of the last search.
- best_idx  out  IDX_W  index of best_dist.

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - start=1 and cand_num>0: latch N, clear the running minimum, go to FETCH.
  - start=1 and cand_num=0: go directly to DONE with found=0, best_dist=all ones, best_idx=0.
- FETCH: rd_en=1 and rd_addr=k for k=0..N-1 on consecutive cycles. After issuing N-1, go to DRAIN.
- DRAIN: consumes the final read's data, then goes to DONE.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- Folding: for each returned sample d at index k:
  - The first sample (k=0) loads unconditionally.
  - Afterwards, if best < d, keep best; otherwise replace best with d and best_idx with k.
  - Ties therefore resolve to the later index, matching the team's pairwise comparator rule.
- Comparison is unsigned, full DIST_W width, with no saturation.
- Results are written to the outputs only in DONE and hold until the next DONE.
- start while busy is ignored: no restart, no queueing.
- rst_n low at any time, including mid-search, immediately forces IDLE and all outputs to reset values. The partial result is discarded.

## Timing
- Reset values: rd_en=0, rd_addr=0, busy=0, done=0, found=0, best_dist=0, best_idx=0.
- Start accepted at edge E0:
  - rd_en is high for exactly N cycles, E0+1 .. E0+N.
  - rd_data is consumed E0+2 .. E0+N+1.
  - done is high in cycle E0+N+2.
  - Start-to-done latency is N+2 cycles.
- N=0: done is high in cycle E0+1 and rd_en never asserts.
- start held high continuously: a new search is accepted in the IDLE cycle after DONE. Back-to-back period is N+3 cycles.
- N=2^IDX_W: rd_addr wraps only after the last read (255 -> stops); no address beyond N-1 is ever issued.

## Structure
- Package min_search_pkg contains:
  - DIST_W and IDX_W defaults.
  - State enum (IDLE, FETCH, DRAIN, DONE).
  - Constant DIST_MAX (all ones).
- Sub-module min_select: combinational pair compare, (a_dist, a_idx, b_dist, b_idx) -> (min_dist, min_idx). It outputs a when a<b, otherwise b. It is instantiated once in the fold path.
- The controller holds the FSM, the read counter, a valid pipe bit (rd_en delayed 1), the running-minimum registers and the output registers.

## Test plan
- N=4, buffer {100, 40, 70, 90} -> done at E0+6; best_dist=40, best_idx=1, found=1; rd_en high exactly 4 cycles with addr 0..3.
- N=3, buffer {50, 50, 50} -> best_idx=2 (tie goes to the later index), best_dist=50.
- N=0 -> done at E0+1, found=0, best_dist=0x3FFFF, best_idx=0, no rd_en.
- N=256, minimum 5 at index 255, all others 0x3FFFF -> best_idx=255, done at E0+258, highest rd_addr 255.
- start pulsed again mid-search (N=8) -> ignored; a single done pulse at E0+10 with the correct result.
- rst_n asserted at E0+3 of an N=8 search -> outputs immediately at reset values; after release, a new start (N=2, {9, 3}) gives best_dist=3, best_idx=1.

Source files
------------

// File: rtl/min_search_pkg.sv
// min_search_pkg: shared widths, FSM state type and distance ceiling for the minimum search
package min_search_pkg;
  localparam int DIST_W_DEF = 18;
  localparam int IDX_W_DEF = 8;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  localparam logic [DIST_W_DEF-1:0] DIST_MAX = '1;
endpackage

// File: rtl/min_select.sv
// min_select: combinational pairwise minimum, a wins only when strictly smaller
// ports: a_dist/a_idx, b_dist/b_idx candidates in; min_dist/min_idx winner out
module min_select
  import min_search_pkg::*;
#(
  parameter int DIST_W = DIST_W_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic [DIST_W-1:0] a_dist,
  input  logic [IDX_W-1:0]  a_idx,
  input  logic [DIST_W-1:0] b_dist,
  input  logic [IDX_W-1:0]  b_idx,
  output logic [DIST_W-1:0] min_dist,
  output logic [IDX_W-1:0]  min_idx
);
  logic a_lt;
  assign a_lt = a_dist < b_dist;
  assign min_dist = a_lt ? a_dist : b_dist;
  assign min_idx = a_lt ? a_idx : b_idx;
endmodule

// File: rtl/min_search_ctrl.sv
// min_search_ctrl: reads N candidate distances one per cycle and reports the minimum and its index
// ports: start/cand_num launch a search; rd_en/rd_addr/rd_data access the candidate buffer
//        (data one cycle after rd_en); busy while searching; done pulses with found/best_dist/best_idx valid
module min_search_ctrl
  import min_search_pkg::*;
#(
  parameter int DIST_W = DIST_W_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [IDX_W:0]    cand_num,
  output logic              rd_en,
  output logic [IDX_W-1:0]  rd_addr,
  input  logic [DIST_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [DIST_W-1:0] best_dist,
  output logic [IDX_W-1:0]  best_idx
);
  state_t state, nxt;
  logic [IDX_W-1:0] cnt, last_idx, vidx, run_idx, sel_idx, fold_idx;
  logic [DIST_W-1:0] run_dist, sel_dist, fold_dist;
  logic vld, launch, empty;
  assign launch = state == IDLE && start;
  assign empty = cand_num == '0;
  assign rd_addr = cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    rd_en = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      IDLE: nxt = start ? (empty ? DONE : FETCH) : IDLE;
      FETCH: begin
        rd_en = 1'b1;
        busy = 1'b1;
        nxt = cnt == last_idx ? DRAIN : FETCH;
      end
      DRAIN: begin
        busy = 1'b1;
        nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end
  min_select #(.DIST_W(DIST_W), .IDX_W(IDX_W)) u_sel (
    .a_dist(run_dist),
    .a_idx(run_idx),
    .b_dist(rd_data),
    .b_idx(vidx),
    .min_dist(sel_dist),
    .min_idx(sel_idx)
  );
  // the first sample of a search loads regardless of the cleared running minimum
  assign fold_dist = vidx == '0 ? rd_data : sel_dist;
  assign fold_idx = vidx == '0 ? vidx : sel_idx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      last_idx <= '0;
      vidx <= '0;
      vld <= 1'b0;
      run_dist <= '0;
      run_idx <= '0;
      found <= 1'b0;
      best_dist <= '0;
      best_idx <= '0;
    end else begin
      vld <= rd_en;
      vidx <= cnt;
      if (launch) begin
        cnt <= '0;
        last_idx <= IDX_W'(cand_num - 1'b1);
        run_dist <= '1;
        run_idx <= '0;
      end else if (rd_en && cnt != last_idx) cnt <= cnt + IDX_W'(1);
      if (vld) begin
        run_dist <= fold_dist;
        run_idx <= fold_idx;
      end
      if (launch && empty) begin
        found <= 1'b0;
        best_dist <= '1;
        best_idx <= '0;
      end
      // DRAIN always carries the last sample, so publish its fold directly so results are valid with done
      if (state == DRAIN) begin
        found <= 1'b1;
        best_dist <= fold_dist;
        best_idx <= fold_idx;
      end
    end
endmodule

// File: tb/tb_min_search_ctrl.sv
// tb_min_search_ctrl: randomized self-checking bench for min_search_ctrl against a behavioural model
module tb_min_search_ctrl;
  import min_search_pkg::*;
  localparam int DW = 18;
  localparam int IW = 8;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [IW:0] cand_num = '0;
  logic rd_en, busy, done, found;
  logic [IW-1:0] rd_addr, best_idx;
  logic [DW-1:0] rd_data, best_dist;
  logic [DW-1:0] mem [256];
  int rd_log [$];
  int n_chk = 0, n_err = 0;
  min_search_ctrl #(.DIST_W(DW), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cand_num(cand_num),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
    .done(done), .found(found), .best_dist(best_dist), .best_idx(best_idx)
  );
  always #5 clk = ~clk;
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : DW'($urandom);
  always @(negedge clk) if (rd_en) rd_log.push_back(int'(rd_addr));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model(input int n, output logic [DW-1:0] d, output int idx);
    d = DIST_MAX;
    idx = 0;
    for (int i = 0; i < n; i++) if (mem[i] < d) d = mem[i];
    for (int i = 0; i < n; i++) if (n > 0 && mem[i] == d) idx = i;
  endtask
  task automatic search(input int n, input bit poke);
    logic [DW-1:0] ed;
    int ei, k, extra;
    model(n, ed, ei);
    @(negedge clk);
    rd_log.delete();
    start = 1'b1;
    cand_num = (IW + 1)'(n);
    @(negedge clk);
    start = 1'b0;
    k = 1;
    if (n > 0) chk("busy_on", busy, 1);
    while (!done && k < n + 10) begin
      start = poke && k == 3;
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk("latency", k, n == 0 ? 1 : n + 2);
    chk("done", done, 1);
    chk("busy_done", busy, 0);
    chk("found", found, n > 0);
    chk("best_dist", best_dist, ed);
    chk("best_idx", best_idx, ei);
    chk("rd_count", rd_log.size(), n);
    for (int i = 0; i < rd_log.size() && i < n; i++) chk("rd_addr", rd_log[i], i);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("hold_dist", best_dist, ed);
    if (poke) begin
      extra = 0;
      repeat (12) begin
        @(negedge clk);
        extra += int'(done);
      end
      chk("no_restart", extra, 0);
    end
  endtask
  initial begin
    logic [DW-1:0] ed;
    int ei, k, n;
    #2;
    chk("rst_rd_en", rd_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dist", best_dist, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mem[0] = 100; mem[1] = 40; mem[2] = 70; mem[3] = 90;
    search(4, 0);
    chk("n4_dist", best_dist, 40);
    chk("n4_idx", best_idx, 1);
    mem[0] = 50; mem[1] = 50; mem[2] = 50;
    search(3, 0);
    chk("tie_idx", best_idx, 2);
    search(0, 0);
    chk("n0_dist", best_dist, 32'h3FFFF);
    for (int i = 0; i < 256; i++) mem[i] = DIST_MAX;
    mem[255] = 5;
    search(256, 0);
    chk("n256_idx", best_idx, 255);
    chk("n256_maxaddr", rd_log.size() > 0 ? rd_log[$] : -1, 255);
    for (int i = 0; i < 8; i++) mem[i] = DW'($urandom_range(1, 1000));
    search(8, 1);
    @(negedge clk);
    start = 1'b1;
    cand_num = 9'd8;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_rd_en", rd_en, 0);
    chk("arst_busy", busy, 0);
    chk("arst_found", found, 0);
    chk("arst_dist", best_dist, 0);
    chk("arst_idx", best_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mem[0] = 9; mem[1] = 3;
    search(2, 0);
    chk("post_rst_dist", best_dist, 3);
    chk("post_rst_idx", best_idx, 1);
    mem[0] = 7; mem[1] = 2; mem[2] = 2;
    @(negedge clk);
    start = 1'b1;
    cand_num = 9'd3;
    k = 0;
    while (!done && k < 20) begin @(negedge clk); k++; end
    @(negedge clk);
    k = 1;
    while (!done && k < 20) begin @(negedge clk); k++; end
    start = 1'b0;
    chk("b2b_period", k, 6);
    chk("b2b_idx", best_idx, 2);
    repeat (3) @(negedge clk);
    repeat (20) begin
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++)
        mem[i] = $urandom_range(0, 3) == 0 ? DW'($urandom) : DW'($urandom_range(0, 6));
      search(n, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
